// File: rtl/wshb_ram_slave.sv
// wshb_ram_slave
//   Wishbone B4 responder backed by an on-chip 32-bit word memory. It serves
//   classic cycles and registered-feedback incrementing bursts (cti=010,
//   bte=00). Writes honour byte selects so frames can be preloaded.
//
// Ports
//   i_clk        Wishbone clock, rising edge
//   i_rst        synchronous active-high reset
//   i_adr        byte address (bits 1:0 ignored), sampled on the first beat only
//   i_dat_ms     write data, master to slave
//   o_dat_sm     read data, slave to master (zero whenever ack is low)
//   i_sel        byte enables, i_sel[i] covers bits 8i+7:8i
//   i_stb/i_cyc  strobe / bus cycle
//   i_we         1 = write, 0 = read
//   i_cti/i_bte  cycle type / burst type
//   o_ack/o_err  beat acknowledge / error termination
//   o_rty        retry, always 0
//
// state  | meaning
// S_IDLE | no transaction; a valid request is checked for range/burst type
// S_WAIT | counting down the wait states before the first beat
// S_BEAT | acknowledging one beat per cycle
// S_ERR  | one-cycle error termination

module wshb_ram_slave #(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_dat_ms,
    output logic [31:0] o_dat_sm,
    input  logic [3:0]  i_sel,
    input  logic        i_stb,
    input  logic        i_cyc,
    input  logic        i_we,
    input  logic [2:0]  i_cti,
    input  logic [1:0]  i_bte,
    output logic        o_ack,
    output logic        o_err,
    output logic        o_rty
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]      CTI_INCR = 3'b010;
    localparam logic [2:0]      LAT      = 3'(LATENCY);
    localparam logic [AW-1:0]   LAST     = AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_ERR} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [AW-1:0]  r_addr;
    logic [AW-1:0]  w_addr_nxt;
    logic [2:0]     r_wait;
    logic [2:0]     w_wait_nxt;
    logic [31:0]    r_rdata;
    logic [31:0]    r_mem [DEPTH];

    logic           w_req;
    logic           w_bad;
    logic           w_ack_q;
    logic           w_err_q;
    logic           w_wr;
    logic [29:0]    w_word;
    logic [AW-1:0]  w_adr_idx;
    logic           w_unused;

    assign w_req     = i_cyc & i_stb;
    assign w_word    = i_adr[31:2];
    assign w_adr_idx = i_adr[AW+1:2];
    assign w_bad     = (w_word >= 30'(DEPTH)) || ((i_cti == CTI_INCR) && (i_bte != 2'b00));
    assign w_unused  = ^i_adr[1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_wait_nxt  = r_wait;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_bad) begin
                        w_state_nxt = S_ERR;
                    end else begin
                        w_addr_nxt  = w_adr_idx;
                        w_wait_nxt  = LAT;
                        w_state_nxt = (LAT == 3'd0) ? S_BEAT : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!w_req) begin
                    w_state_nxt = S_IDLE;
                end else if (r_wait <= 3'd1) begin
                    // last wait state: the counter hits zero on this edge
                    w_wait_nxt  = 3'd0;
                    w_state_nxt = S_BEAT;
                end else begin
                    w_wait_nxt = r_wait - 3'd1;
                end
            end
            S_BEAT: begin
                if (w_req && (i_cti == CTI_INCR)) begin
                    w_addr_nxt = (r_addr == LAST) ? '0 : r_addr + 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_ack_q = 1'b0;
        w_err_q = 1'b0;
        case (r_state)
            S_BEAT:  w_ack_q = 1'b1;
            S_ERR:   w_err_q = 1'b1;
            default: ;
        endcase
    end

    // Gating with i_rst keeps the bus quiet while reset is held and blocks
    // the memory write on the edge where reset is sampled.
    assign o_ack    = w_ack_q & w_req & ~i_rst;
    assign o_err    = w_err_q & w_req & ~i_rst;
    assign o_rty    = 1'b0;
    assign o_dat_sm = (o_ack & ~i_we) ? r_rdata : 32'h0;
    assign w_wr     = o_ack & i_we;

    // The read register always fetches the word the next cycle will address,
    // which gives the one-beat prefetch that keeps bursts bubble-free.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr  <= '0;
            r_wait  <= 3'd0;
            r_rdata <= 32'h0;
        end else begin
            r_addr  <= w_addr_nxt;
            r_wait  <= w_wait_nxt;
            r_rdata <= r_mem[w_addr_nxt];
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (i_sel[i]) begin
                    r_mem[r_addr][8*i +: 8] <= i_dat_ms[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wshb_ram_slave.sv
module tb_wshb_ram_slave;

    localparam int DEPTH = 4096;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] m_mem [DEPTH];

    typedef struct {
        bit          we;
        logic [31:0] adr;
        int          nb;
        bit          burst;
        bit          end111;
        logic [1:0]  bte;
        logic [3:0]  sel;
        logic [31:0] wbase;
        bit          exp_err;
        bit          chk0;
        logic [31:0] rd0;
    } vec_t;

    vec_t vt [13];

    wshb_ram_slave #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_adr    (adr),
        .i_dat_ms (dat_ms),
        .o_dat_sm (dat_sm),
        .i_sel    (sel),
        .i_stb    (stb),
        .i_cyc    (cyc),
        .i_we     (we),
        .i_cti    (cti),
        .i_bte    (bte),
        .o_ack    (ack),
        .o_err    (err),
        .o_rty    (rty)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic idle_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; bte = 2'b00;
        sel = 4'h0; adr = 32'h0; dat_ms = 32'h0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // One transaction, driven and checked cycle by cycle. Cycle 0 is the
    // cycle in which stb rises; beats are expected in cycles LAT+1..LAT+nb.
    task automatic run_txn(input bit w, input logic [31:0] a, input int nb, input bit burst,
                           input bit end111, input logic [1:0] bt, input logic [3:0] s,
                           input logic [31:0] wbase, input bit exp_err, input bit chk0,
                           input logic [31:0] rd0);
        int last_c, b, word0, wd;
        bit exp_ack, exp_er;
        word0  = int'(a[31:2]);
        last_c = exp_err ? 1 : LAT + nb;
        for (int c = 0; c <= last_c + 1; c++) begin
            b = (c >= LAT + 1) ? c - LAT - 1 : 0;
            if (c <= last_c) begin
                cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; bte = bt;
                dat_ms = wbase + 32'(b) * 32'h01010101;
                if (!burst) cti = 3'b000;
                else if (end111 && (b == nb - 1) && (c >= LAT + 1)) cti = 3'b111;
                else cti = 3'b010;
            end else begin
                idle_bus();
            end
            @(negedge clk);
            exp_ack = !exp_err && (c >= LAT + 1) && (c <= LAT + nb);
            exp_er  = exp_err && (c == 1);
            chk("ack", {31'b0, ack}, {31'b0, exp_ack});
            chk("err", {31'b0, err}, {31'b0, exp_er});
            wd = (word0 + b) % DEPTH;
            if (exp_ack && !w) begin
                chk("rdata_model", dat_sm, m_mem[wd]);
                if (chk0 && b == 0) chk("rdata_first", dat_sm, rd0);
            end else if (!exp_ack) begin
                chk("dat_zero", dat_sm, 32'h0);
            end
            @(posedge clk);
            if (exp_ack && w) m_mem[wd] = merge(m_mem[wd], wbase + 32'(b) * 32'h01010101, s);
            #1;
        end
    endtask

    initial begin
        int b, nb, wstart;
        bit w, burst, e111, eerr;
        logic [3:0] s;
        logic [1:0] bt;
        bit exp_ack;

        vt[0]  = '{1'b1, 32'h10, 1, 1'b0, 1'b0, 2'b00, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b0, 32'h10, 1, 1'b0, 1'b0, 2'b00, 4'hF, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 32'h10, 1, 1'b0, 1'b0, 2'b00, 4'h5, 32'h11223344, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 32'h10, 1, 1'b0, 1'b0, 2'b00, 4'hF, 32'h0, 1'b0, 1'b1, 32'hDE22BE44};
        vt[4]  = '{1'b1, 32'h0, 8, 1'b1, 1'b1, 2'b00, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0};
        vt[5]  = '{1'b0, 32'h0, 5, 1'b1, 1'b0, 2'b00, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0};
        vt[6]  = '{1'b0, 32'h14, 3, 1'b1, 1'b1, 2'b00, 4'hF, 32'h0, 1'b0, 1'b1, 32'h05050505};
        vt[7]  = '{1'b1, 32'(DEPTH * 4), 1, 1'b0, 1'b0, 2'b00, 4'hF, 32'hBAD0BAD0, 1'b1, 1'b0, 32'h0};
        vt[8]  = '{1'b0, 32'h0, 1, 1'b0, 1'b0, 2'b00, 4'hF, 32'h0, 1'b0, 1'b1, 32'h0};
        vt[9]  = '{1'b1, 32'((DEPTH - 1) * 4), 2, 1'b1, 1'b1, 2'b00, 4'hF, 32'hA5A50000, 1'b0, 1'b0, 32'h0};
        vt[10] = '{1'b0, 32'((DEPTH - 1) * 4), 2, 1'b1, 1'b1, 2'b00, 4'hF, 32'h0, 1'b0, 1'b1, 32'hA5A50000};
        vt[11] = '{1'b0, 32'h20, 1, 1'b1, 1'b1, 2'b01, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0};
        vt[12] = '{1'b0, 32'h0, 1, 1'b0, 1'b0, 2'b00, 4'hF, 32'h0, 1'b0, 1'b1, 32'hA6A60101};

        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;

        // Reset held for three cycles with a live request on the bus.
        idle_bus();
        rst = 1'b1; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ack", {31'b0, ack}, 32'h0);
            chk("rst_err", {31'b0, err}, 32'h0);
            chk("rst_dat", dat_sm, 32'h0);
            chk("rst_rty", {31'b0, rty}, 32'h0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        for (int c = 0; c <= LAT + 1; c++) begin
            @(negedge clk);
            chk("post_rst_ack", {31'b0, ack}, {31'b0, c == LAT + 1});
            chk("post_rst_err", {31'b0, err}, 32'h0);
            @(posedge clk); #1;
        end
        idle_bus();
        @(negedge clk);
        chk("idle_ack", {31'b0, ack}, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++)
            run_txn(vt[i].we, vt[i].adr, vt[i].nb, vt[i].burst, vt[i].end111, vt[i].bte,
                    vt[i].sel, vt[i].wbase, vt[i].exp_err, vt[i].chk0, vt[i].rd0);

        // Reset during the third beat of a write burst.
        run_txn(1'b1, 32'h80, 3, 1'b1, 1'b1, 2'b00, 4'hF, 32'h11111111, 1'b0, 1'b0, 32'h0);
        for (int c = 0; c <= LAT + 4; c++) begin
            b = (c >= LAT + 1) ? c - LAT - 1 : 0;
            rst = (c == LAT + 3);
            if (c <= LAT + 3) begin
                cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h80; cti = 3'b010;
                bte = 2'b00; sel = 4'hF; dat_ms = 32'h77000000 + 32'(b) * 32'h01010101;
            end else begin
                idle_bus();
            end
            @(negedge clk);
            exp_ack = (c == LAT + 1) || (c == LAT + 2);
            chk("mid_rst_ack", {31'b0, ack}, {31'b0, exp_ack});
            chk("mid_rst_err", {31'b0, err}, 32'h0);
            if (!exp_ack) chk("mid_rst_dat", dat_sm, 32'h0);
            @(posedge clk);
            if (exp_ack) m_mem[32 + b] = 32'h77000000 + 32'(b) * 32'h01010101;
            #1;
        end
        rst = 1'b0;
        run_txn(1'b0, 32'h80, 3, 1'b1, 1'b1, 2'b00, 4'hF, 32'h0, 1'b0, 1'b1, 32'h77000000);
        run_txn(1'b0, 32'h88, 1, 1'b0, 1'b0, 2'b00, 4'hF, 32'h0, 1'b0, 1'b1, 32'h13131313);

        // Randomized traffic over a preloaded window, including the wrap point.
        run_txn(1'b1, 32'h0, 16, 1'b1, 1'b1, 2'b00, 4'hF, $urandom, 1'b0, 1'b0, 32'h0);
        run_txn(1'b1, 32'((DEPTH - 4) * 4), 4, 1'b1, 1'b1, 2'b00, 4'hF, $urandom, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 40; i++) begin
            w      = 1'($urandom_range(0, 1));
            nb     = int'($urandom_range(1, 6));
            burst  = (nb > 1) ? 1'b1 : 1'($urandom_range(0, 1));
            e111   = 1'($urandom_range(0, 1));
            s      = w ? 4'($urandom_range(0, 15)) : 4'hF;
            wstart = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 9))
                                                 : DEPTH - 4 + int'($urandom_range(0, 3));
            eerr   = burst && ($urandom_range(0, 7) == 0);
            bt     = eerr ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(w, 32'(wstart * 4), nb, burst, e111, bt, s, $urandom, eerr, 1'b0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/wshb_ram_slave.md
Name: wshb_ram_slave

Overview:
- Wishbone B4 responder backed by an on-chip word memory. It is the slave end of the read bursts issued by the display controller: classic cycles plus registered-feedback incrementing bursts (cti=010, bte=00).
- It lets the frame-fetch path be simulated and run on FPGA without the SDRAM controller.
- It also accepts writes, with byte selects, so a bench or test-pattern writer can preload frames.

Parameters:
- DEPTH, 4096, memory size in 32-bit words; word index = adr[31:2].
- LATENCY, 2, wait states before the first beat of a transaction (0..7).

Ports:
- clk  in  1  Wishbone clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- adr  in  32  byte address, word aligned (adr[1:0] ignored).
- dat_ms  in  32  write data, master to slave.
- dat_sm  out  32  read data, slave to master.
- sel  in  4  byte enables; sel[i] covers bits 8i+7:8i.
- stb  in  1  strobe.
- cyc  in  1  bus cycle.
- we  in  1  1 = write, 0 = read.
- cti  in  3  000 classic, 010 incrementing burst, 111 end of burst.
- bte  in  2  burst type; only 00 (linear) is supported.
- ack  out  1  beat acknowledge.
- err  out  1  error termination.
- rty  out  1  tied 0.

Behaviour:
- A request is valid when cyc & stb. Request attributes (we, sel, dat_ms, cti, bte) are sampled on every beat. adr is sampled only at the first beat; later burst beats use an internal word counter.
- Output qualification: ack = ack_q & cyc & stb and err = err_q & cyc & stb, so a beat is never acknowledged after the master has dropped stb.
- FSM states:
  - IDLE: on a valid request, evaluate the start condition.
    - If adr[31:2] >= DEPTH, or cti=010 with bte != 00, go to ERR.
    - Otherwise load addr_cnt <= adr[31:2], wait_cnt <= LATENCY, and go to WAIT. When LATENCY=0, go directly to BEAT.
  - WAIT: decrement wait_cnt; when it reaches 0, go to BEAT. If cyc or stb is low, abort to IDLE with no ack and no write.
  - BEAT: ack_q = 1.
    - When ack & we, mem[addr_cnt] byte lanes with sel=1 are updated at the end of the cycle.
    - When ack & !we, dat_sm = mem[addr_cnt].
    - If cti=010 and stb & cyc, stay in BEAT with addr_cnt <= (addr_cnt+1) mod DEPTH. A burst therefore acks one beat per cycle with no further wait states.
    - Otherwise (cti 000/111, or stb/cyc low) go to IDLE. A new request re-pays LATENCY.
  - ERR: err_q = 1 for exactly one cycle, then IDLE. No ack, no memory write.
- Latency: when stb first rises in cycle N from IDLE, the first ack occurs in cycle N+LATENCY+1, and an error in cycle N+1.
- Reads need a one-cycle prefetch of mem[addr_cnt+1] so that back-to-back burst beats have zero bubbles.
- dat_sm = 32'h0 whenever ack is low.
- Read-after-write: a read of an address written by an earlier completed beat returns the new data.
- Address wrap: a burst crossing word DEPTH-1 continues at word 0.
- Reset, synchronous:
  - Every edge with rst=1 forces IDLE, ack_q=0, err_q=0, counters to 0; hence ack=0, err=0, dat_sm=0, rty=0.
  - No memory write occurs on an edge where rst is sampled high.
  - Memory contents are not cleared by reset.
  - A burst in progress when rst rises is dropped; after rst falls, the next request pays full latency.
- ack and err are never high in the same cycle.

Test Plan:
1. Reset: hold rst 3 cycles while cyc=stb=1 -> ack=err=0, dat_sm=0 throughout; first ack appears LATENCY+1 cycles after rst falls.
2. Classic write then read, LATENCY=2, stb rises in cycle 0 each time:
   - write adr=0x10, dat_ms=0xDEADBEEF, sel=1111, cti=000 -> ack only in cycle 3;
   - then read adr=0x10 -> ack in cycle 3, dat_sm=0xDEADBEEF.
3. Byte select: write 0x11223344 with sel=0101 to adr 0x10 -> subsequent read returns 0xDE22BE44.
4. Burst read, with words 0..7 preloaded to i*0x01010101, adr=0, cti=010 held:
   - ack in cycles 3..7 with data 0x00000000..0x04040404;
   - drop stb after 5th ack -> exactly 5 acks;
   - restart at adr=0x14 -> ack again after 2 wait states, data 0x05050505.
5. Error and wrap:
   - adr=DEPTH*4 -> err one cycle at cycle 1, no ack, memory unchanged;
   - burst from adr=(DEPTH-1)*4 -> second beat returns word 0;
   - bte=01 with cti=010 -> err.
6. Reset mid-burst: assert rst during the 3rd write beat -> ack low on that edge, that beat not written, earlier beats retained.
